// File: rtl/writeback_merge_stage_pkg.sv
// Shared types and constants for the writeback merge stage.
//   thread_idx_t / subcycle_t / reg_idx_t : field widths of a completing instruction
//   pipeline_sel_t                        : which execution pipeline produced a result
//   wb_source_t                           : completion record presented by each pipeline
//   SQUASH_CYCLES_DEFAULT                 : post-rollback discard window per thread
package writeback_merge_stage_pkg;

  localparam int THREADS          = 4;  // hardware threads per core
  localparam int THREAD_IDX_WIDTH = $clog2(THREADS);
  localparam int SUBCYCLE_WIDTH   = 4;

  typedef logic [THREAD_IDX_WIDTH-1:0] thread_idx_t;
  typedef logic [SUBCYCLE_WIDTH-1:0]   subcycle_t;
  typedef logic [4:0]                  reg_idx_t;
  typedef logic [2:0]                  squash_count_t;

  localparam squash_count_t SQUASH_CYCLES_DEFAULT = 3'd5;

  typedef enum logic [1:0] {
    PIPE_SCYCLE_ARITH = 2'd0,
    PIPE_MCYCLE_ARITH = 2'd1,
    PIPE_MEM          = 2'd2
  } pipeline_sel_t;

  typedef struct packed {
    thread_idx_t thread_idx;
    logic        has_dest;
    logic        is_vector;
    reg_idx_t    dest_reg;
    subcycle_t   subcycle;
    logic        last_subcycle;
    logic        rollback_req;
    logic [31:0] rollback_pc;
  } wb_source_t;

  function automatic logic [THREADS-1:0] thread_onehot(input thread_idx_t t);
    logic [THREADS-1:0] one;
    one = 1;
    return one << t;
  endfunction

endpackage

// File: rtl/wb_squash_tracker.sv
// Per-thread squash window tracker.
//   clk, reset      : clock, asynchronous active-high reset
//   rollback_en     : a rollback is being taken this cycle
//   rollback_thread : thread being rolled back
//   query_thread    : thread of the instruction completing this cycle
//   squashed        : query_thread is still inside its discard window
module wb_squash_tracker
  import writeback_merge_stage_pkg::*;
#(
  parameter squash_count_t SQUASH_CYCLES = SQUASH_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rollback_en,
  input  thread_idx_t rollback_thread,
  input  thread_idx_t query_thread,
  output logic        squashed
);

  squash_count_t count [THREADS];

  // NOTE: the counter array is reset explicitly; a stale non-zero count
  // after reset would silently swallow the first completions of a thread.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < THREADS; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < THREADS; i++) begin
        // NOTE: non-blocking assignments keep every counter update based on
        // the pre-edge values, independent of loop order.
        if (rollback_en && rollback_thread == thread_idx_t'(i))
          count[i] <= SQUASH_CYCLES;
        else if (count[i] != '0)
          count[i] <= count[i] - 3'd1;
      end
    end
  end

  // The top never requests a rollback for a squashed thread, so a reload
  // cannot extend an already-running window.
  assign squashed = (count[query_thread] != '0);

endmodule

// File: rtl/writeback_merge_stage.sv
// Final pipeline stage: merges SC / MC / MEM completions into one register
// writeback port, generates branch and dcache-miss-replay rollbacks, squashes
// in-flight work of rolled-back threads and raises the dcache-miss suspend.
//   clk, reset                     : clock, asynchronous active-high reset
//   {sc,mc,mem}_valid / _result    : completing instruction per pipeline (at most one valid)
//   mem_cache_miss                 : MEM completion missed the dcache (replay + suspend)
//   wb_writeback_*                 : register file write port (1-cycle latency)
//   wb_rollback_*                  : rollback request to thread select (1-cycle latency)
//   wb_suspend_thread_oh           : one-hot suspend, one cycle after the miss rollback
//   perf_retire                    : one pulse per retired instruction
module writeback_merge_stage
  import writeback_merge_stage_pkg::*;
#(
  parameter squash_count_t SQUASH_CYCLES = SQUASH_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sc_valid,
  input  wb_source_t         sc_result,
  input  logic               mc_valid,
  input  wb_source_t         mc_result,
  input  logic               mem_valid,
  input  wb_source_t         mem_result,
  input  logic               mem_cache_miss,
  output logic               wb_writeback_en,
  output thread_idx_t        wb_writeback_thread_idx,
  output logic               wb_writeback_is_vector,
  output reg_idx_t           wb_writeback_reg,
  output logic               wb_writeback_is_last_subcycle,
  output logic               wb_rollback_en,
  output thread_idx_t        wb_rollback_thread_idx,
  output pipeline_sel_t      wb_rollback_pipeline,
  output subcycle_t          wb_rollback_subcycle,
  output logic [31:0]        wb_rollback_pc,
  output logic [THREADS-1:0] wb_suspend_thread_oh,
  output logic               perf_retire
);

  wb_source_t    src;
  pipeline_sel_t src_pipe;
  logic          any_valid;
  logic          replay;
  logic          squashed;
  logic          live;
  logic          do_writeback;
  logic          do_rollback;
  logic          do_retire;
  logic          suspend_pending;
  thread_idx_t   suspend_thread;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned (which would infer a latch).
  always_comb begin
    src      = '0;
    src_pipe = PIPE_SCYCLE_ARITH;
    if (sc_valid) begin
      src      = sc_result;
      src_pipe = PIPE_SCYCLE_ARITH;
    end else if (mc_valid) begin
      src      = mc_result;
      src_pipe = PIPE_MCYCLE_ARITH;
    end else if (mem_valid) begin
      src      = mem_result;
      src_pipe = PIPE_MEM;
    end
  end

  assign any_valid = sc_valid | mc_valid | mem_valid;
  assign replay    = mem_valid & mem_cache_miss;

  wb_squash_tracker #(
    .SQUASH_CYCLES (SQUASH_CYCLES)
  ) u_squash (
    .clk             (clk),
    .reset           (reset),
    .rollback_en     (do_rollback),
    .rollback_thread (src.thread_idx),
    .query_thread    (src.thread_idx),
    .squashed        (squashed)
  );

  // A squashed completion is dropped entirely: no writeback, rollback,
  // suspend or retire.
  assign live         = any_valid & ~squashed;
  assign do_rollback  = live & (src.rollback_req | replay);
  assign do_writeback = live & src.has_dest & ~replay;   // branches still write the link reg
  assign do_retire    = live & src.last_subcycle & ~replay;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_writeback_en               <= 1'b0;
      wb_writeback_thread_idx       <= '0;
      wb_writeback_is_vector        <= 1'b0;
      wb_writeback_reg              <= '0;
      wb_writeback_is_last_subcycle <= 1'b0;
      wb_rollback_en                <= 1'b0;
      wb_rollback_thread_idx        <= '0;
      wb_rollback_pipeline          <= PIPE_SCYCLE_ARITH;
      wb_rollback_subcycle          <= '0;
      wb_rollback_pc                <= '0;
      wb_suspend_thread_oh          <= '0;
      perf_retire                   <= 1'b0;
      suspend_pending               <= 1'b0;
      suspend_thread                <= '0;
    end else begin
      wb_writeback_en               <= do_writeback;
      wb_writeback_thread_idx       <= do_writeback ? src.thread_idx : '0;
      wb_writeback_is_vector        <= do_writeback & src.is_vector;
      wb_writeback_reg              <= do_writeback ? src.dest_reg : '0;
      wb_writeback_is_last_subcycle <= do_writeback & src.last_subcycle;

      wb_rollback_en                <= do_rollback;
      wb_rollback_thread_idx        <= do_rollback ? src.thread_idx : '0;
      wb_rollback_pipeline          <= do_rollback ? src_pipe : PIPE_SCYCLE_ARITH;
      wb_rollback_subcycle          <= do_rollback ? src.subcycle : '0;
      wb_rollback_pc                <= do_rollback ? src.rollback_pc : '0;

      perf_retire                   <= do_retire;

      // The suspend trails the replay rollback by one cycle; the pending
      // stage is cleared by reset so a reset mid-miss drops the suspend.
      suspend_pending               <= live & replay;
      suspend_thread                <= src.thread_idx;
      wb_suspend_thread_oh          <= suspend_pending ? thread_onehot(suspend_thread) : '0;
    end
  end

  // The issue side guarantees a single completing pipeline per cycle.
  a_one_source: assert property (@(posedge clk) disable iff (reset)
    $onehot0({sc_valid, mc_valid, mem_valid}));

endmodule

// File: tb/tb_writeback_merge_stage.sv
// Directed self-checking bench for writeback_merge_stage.
module tb_writeback_merge_stage;
  import writeback_merge_stage_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               sc_valid, mc_valid, mem_valid, mem_cache_miss;
  wb_source_t         sc_result, mc_result, mem_result;
  logic               wb_writeback_en;
  thread_idx_t        wb_writeback_thread_idx;
  logic               wb_writeback_is_vector;
  reg_idx_t           wb_writeback_reg;
  logic               wb_writeback_is_last_subcycle;
  logic               wb_rollback_en;
  thread_idx_t        wb_rollback_thread_idx;
  pipeline_sel_t      wb_rollback_pipeline;
  subcycle_t          wb_rollback_subcycle;
  logic [31:0]        wb_rollback_pc;
  logic [THREADS-1:0] wb_suspend_thread_oh;
  logic               perf_retire;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_merge_stage dut (
    .clk                           (clk),
    .reset                         (reset),
    .sc_valid                      (sc_valid),
    .sc_result                     (sc_result),
    .mc_valid                      (mc_valid),
    .mc_result                     (mc_result),
    .mem_valid                     (mem_valid),
    .mem_result                    (mem_result),
    .mem_cache_miss                (mem_cache_miss),
    .wb_writeback_en               (wb_writeback_en),
    .wb_writeback_thread_idx       (wb_writeback_thread_idx),
    .wb_writeback_is_vector        (wb_writeback_is_vector),
    .wb_writeback_reg              (wb_writeback_reg),
    .wb_writeback_is_last_subcycle (wb_writeback_is_last_subcycle),
    .wb_rollback_en                (wb_rollback_en),
    .wb_rollback_thread_idx        (wb_rollback_thread_idx),
    .wb_rollback_pipeline          (wb_rollback_pipeline),
    .wb_rollback_subcycle          (wb_rollback_subcycle),
    .wb_rollback_pc                (wb_rollback_pc),
    .wb_suspend_thread_oh          (wb_suspend_thread_oh),
    .perf_retire                   (perf_retire)
  );

  // Packed views of the output groups: {en, thread, vec, reg, last}, {en, thread, pipe, subcycle, pc}
  wire [9:0]  wb_obs = {wb_writeback_en, wb_writeback_thread_idx, wb_writeback_is_vector,
                        wb_writeback_reg, wb_writeback_is_last_subcycle};
  wire [40:0] rb_obs = {wb_rollback_en, wb_rollback_thread_idx, wb_rollback_pipeline,
                        wb_rollback_subcycle, wb_rollback_pc};

  function automatic wb_source_t mk(input thread_idx_t t, input logic dest, input logic vec,
                                    input reg_idx_t r, input subcycle_t sub, input logic last,
                                    input logic rb, input logic [31:0] pc);
    wb_source_t s;
    s = '{thread_idx: t, has_dest: dest, is_vector: vec, dest_reg: r, subcycle: sub,
          last_subcycle: last, rollback_req: rb, rollback_pc: pc};
    return s;
  endfunction

  task automatic clear_inputs();
    sc_valid = 0; mc_valid = 0; mem_valid = 0; mem_cache_miss = 0;
    sc_result = '0; mc_result = '0; mem_result = '0;
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({wb_obs, rb_obs, wb_suspend_thread_oh, perf_retire} !== '0) begin
      $display("FAIL %s: outputs got wb=%h rb=%h susp=%b perf=%b expected all zero",
               name, wb_obs, rb_obs, wb_suspend_thread_oh, perf_retire);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 0;
    step();
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_sc_writeback();
    sc_valid = 1; sc_result = mk(2'd1, 1, 0, 5'd5, 4'd0, 1, 0, 32'h0);
    step(); clear_inputs();
    checks++;
    if (wb_obs !== {1'b1, 2'd1, 1'b0, 5'd5, 1'b1}) begin
      $display("FAIL sc_writeback: got %h expected %h", wb_obs, {1'b1, 2'd1, 1'b0, 5'd5, 1'b1}); errors++;
    end
    checks++;
    if ({perf_retire, wb_rollback_en} !== 2'b10) begin
      $display("FAIL sc_perf_no_rb: got %b expected 10", {perf_retire, wb_rollback_en}); errors++;
    end
    step();
    check_all_zero("sc_one_cycle_only");
  endtask

  task automatic test_mem_miss();
    mem_valid = 1; mem_cache_miss = 1; mem_result = mk(2'd2, 1, 1, 5'd3, 4'd4, 1, 0, 32'h2468);
    step(); clear_inputs();
    checks++;
    if (rb_obs !== {1'b1, 2'd2, PIPE_MEM, 4'd4, 32'h2468}) begin
      $display("FAIL miss_rollback: got %h expected %h", rb_obs, {1'b1, 2'd2, PIPE_MEM, 4'd4, 32'h2468}); errors++;
    end
    checks++;
    if ({wb_writeback_en, perf_retire, wb_suspend_thread_oh} !== 6'b0) begin
      $display("FAIL miss_no_wb: got %b expected 000000",
               {wb_writeback_en, perf_retire, wb_suspend_thread_oh}); errors++;
    end
    step();
    checks++;
    if ({wb_suspend_thread_oh, wb_rollback_en} !== 5'b0100_0) begin
      $display("FAIL miss_suspend: got %b expected 01000", {wb_suspend_thread_oh, wb_rollback_en}); errors++;
    end
    step();
    check_all_zero("miss_suspend_one_wide");
  endtask

  task automatic test_branch();
    sc_valid = 1; sc_result = mk(2'd0, 1, 0, 5'd31, 4'd0, 1, 1, 32'h1000);
    step(); clear_inputs();
    checks++;
    if (wb_obs !== {1'b1, 2'd0, 1'b0, 5'd31, 1'b1}) begin
      $display("FAIL branch_link_wb: got %h expected %h", wb_obs, {1'b1, 2'd0, 1'b0, 5'd31, 1'b1}); errors++;
    end
    checks++;
    if (rb_obs !== {1'b1, 2'd0, PIPE_SCYCLE_ARITH, 4'd0, 32'h1000}) begin
      $display("FAIL branch_rollback: got %h expected %h", rb_obs,
               {1'b1, 2'd0, PIPE_SCYCLE_ARITH, 4'd0, 32'h1000}); errors++;
    end
  endtask

  task automatic test_squash_window();
    sc_valid = 1; sc_result = mk(2'd0, 0, 0, 5'd0, 4'd0, 0, 1, 32'h40);   // rollback at N
    step();
    checks++;
    if (rb_obs !== {1'b1, 2'd0, PIPE_SCYCLE_ARITH, 4'd0, 32'h40}) begin
      $display("FAIL squash_rollback: got %h expected %h", rb_obs,
               {1'b1, 2'd0, PIPE_SCYCLE_ARITH, 4'd0, 32'h40}); errors++;
    end
    // N+1..N+5: squashed; the rollback_req at N+3 must not reload the window
    for (int i = 1; i <= 5; i++) begin
      clear_inputs();
      mc_valid = 1; mc_result = mk(2'd0, 1, 0, 5'd7, 4'd0, 1, (i == 3), 32'h80);
      step();
      checks++;
      if ({wb_writeback_en, wb_rollback_en, perf_retire} !== 3'b000) begin
        $display("FAIL squashed_n_plus_%0d: got %b expected 000", i,
                 {wb_writeback_en, wb_rollback_en, perf_retire}); errors++;
      end
    end
    clear_inputs();
    mc_valid = 1; mc_result = mk(2'd0, 1, 0, 5'd7, 4'd0, 1, 0, 32'h0);   // N+6
    step(); clear_inputs();
    checks++;
    if ({wb_obs, perf_retire} !== {1'b1, 2'd0, 1'b0, 5'd7, 1'b1, 1'b1}) begin
      $display("FAIL squash_expired_wb: got %h expected %h", {wb_obs, perf_retire},
               {1'b1, 2'd0, 1'b0, 5'd7, 1'b1, 1'b1}); errors++;
    end
  endtask

  task automatic test_thread_independence();
    sc_valid = 1; sc_result = mk(2'd0, 0, 0, 5'd0, 4'd0, 0, 1, 32'h200);  // t0 rollback at N
    step(); clear_inputs();
    sc_valid = 1; sc_result = mk(2'd1, 1, 0, 5'd2, 4'd0, 1, 0, 32'h0);    // t1 at N+1
    step(); clear_inputs();
    checks++;
    if (wb_obs !== {1'b1, 2'd1, 1'b0, 5'd2, 1'b1}) begin
      $display("FAIL other_thread_wb: got %h expected %h", wb_obs, {1'b1, 2'd1, 1'b0, 5'd2, 1'b1}); errors++;
    end
    mc_valid = 1; mc_result = mk(2'd0, 1, 0, 5'd9, 4'd0, 1, 0, 32'h0);    // t0 at N+2 still squashed
    step(); clear_inputs();
    checks++;
    if ({wb_writeback_en, perf_retire} !== 2'b00) begin
      $display("FAIL t0_still_squashed: got %b expected 00", {wb_writeback_en, perf_retire}); errors++;
    end
  endtask

  task automatic test_suspend_with_rollback();
    mem_valid = 1; mem_cache_miss = 1; mem_result = mk(2'd3, 1, 0, 5'd1, 4'd2, 1, 0, 32'h300);
    step(); clear_inputs();
    sc_valid = 1; sc_result = mk(2'd1, 0, 0, 5'd0, 4'd0, 1, 1, 32'h500);
    step(); clear_inputs();
    checks++;
    if (rb_obs !== {1'b1, 2'd1, PIPE_SCYCLE_ARITH, 4'd0, 32'h500}) begin
      $display("FAIL concurrent_rollback: got %h expected %h", rb_obs,
               {1'b1, 2'd1, PIPE_SCYCLE_ARITH, 4'd0, 32'h500}); errors++;
    end
    checks++;
    if (wb_suspend_thread_oh !== 4'b1000) begin
      $display("FAIL concurrent_suspend: got %b expected 1000", wb_suspend_thread_oh); errors++;
    end
  endtask

  task automatic test_back_to_back();
    sc_valid = 1; sc_result = mk(2'd2, 1, 0, 5'd4, 4'd0, 0, 0, 32'h0);
    step(); clear_inputs();
    mc_valid = 1; mc_result = mk(2'd3, 1, 1, 5'd6, 4'd3, 1, 0, 32'h0);
    checks++;
    if ({wb_obs, perf_retire} !== {1'b1, 2'd2, 1'b0, 5'd4, 1'b0, 1'b0}) begin
      $display("FAIL b2b_first: got %h expected %h", {wb_obs, perf_retire},
               {1'b1, 2'd2, 1'b0, 5'd4, 1'b0, 1'b0}); errors++;
    end
    step(); clear_inputs();
    checks++;
    if ({wb_obs, perf_retire} !== {1'b1, 2'd3, 1'b1, 5'd6, 1'b1, 1'b1}) begin
      $display("FAIL b2b_second: got %h expected %h", {wb_obs, perf_retire},
               {1'b1, 2'd3, 1'b1, 5'd6, 1'b1, 1'b1}); errors++;
    end
  endtask

  task automatic test_reset_mid_miss();
    mem_valid = 1; mem_cache_miss = 1; mem_result = mk(2'd2, 1, 0, 5'd8, 4'd1, 1, 0, 32'h700);
    step(); clear_inputs();
    checks++;
    if (wb_rollback_en !== 1'b1) begin
      $display("FAIL mid_miss_rollback: got %b expected 1", wb_rollback_en); errors++;
    end
    reset = 1;
    #2;
    check_all_zero("mid_miss_reset_async");
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_all_zero("mid_miss_no_suspend");
    end
  endtask

  initial begin
    fork
      begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_sc_writeback();
    test_mem_miss();
    idle(8);
    test_branch();
    idle(8);
    test_squash_window();
    idle(8);
    test_thread_independence();
    idle(8);
    test_suspend_with_rollback();
    idle(8);
    test_back_to_back();
    idle(8);
    test_reset_mid_miss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
